pipe_mac_seq: RTL and testbench
===============================

# pipe_mac_seq

Control sequencer that sits directly upstream of the stochastic MAC datapath (`prg_4b` ×2, `shift_reg_16b` ×2, `pipe_mul_16b`, `prg4b_bank`, `pipe_scale_add_16b`, `ctr_out_bank`). It accepts one MAC job per start/done handshake and latches the operands A, B and C0..C15. It then drives the datapath enables, wrap and reset controls through fixed fill, multiply, add and drain phases, and captures the 8-bit count from `ctr_out_bank` as the job result.

## Interface
Parameters:
- `FILL_CYC`, default 16: cycles spent loading both shift registers (one period of the 4-bit PRG counter).
- `MUL_CYC`, default 17: cycles with A held and B rotating, before the add starts.
- `ADD_CYC`, default 16: cycles with the C bank and scaled add active.
- `DRAIN_CYC`, default 2: pipeline flush cycles before capture.
- `CNT_W`, default 5: width of the phase counter. It must hold (max phase length − 1). Every `*_CYC` must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: job request. Sampled in IDLE or CAPTURE only.
- `a_in`, `b_in`, in, 4 each: A and B operands.
- `c_in`, in, 64: C operands. Cn is `c_in[4n+3:4n]`.
- `acc_in`, in, 8: `bin_out` from `ctr_out_bank`.
- `bin_a`, `bin_b`, out, 4 each: latched A and B, driven to the two `prg_4b` inputs.
- `bin_c`, out, 64: latched C, driven to `prg4b_bank`.
- `dp_rst`, out, 1: reset to the PRGs and shift registers.
- `en_prg`, out, 1: enable for the A/B PRGs.
- `en_sr_a`, `en_sr_b`, out, 1 each: shift register enables.
- `wrap_mode_a`, `wrap_mode_b`, out, 1 each: shift register wrap controls.
- `rst_out`, out, 1: reset to `ctr_out_bank`.
- `en_c_bank`, out, 1: enable for `prg4b_bank`.
- `start_add`, out, 1: `s` input of `pipe_scale_add_16b`.
- `busy`, out, 1: high from CLR through CAPTURE.
- `done`, out, 1: one-cycle pulse marking `result` valid.
- `result`, out, 8: captured accumulator value.

## Operation
- States: IDLE → CLR → FILL → MUL → ADD → DRAIN → CAPTURE → IDLE, or CLR on back-to-back start.
- Phase counter: loads 0 on entry to each timed phase. The phase exits when the counter equals `*_CYC`−1.
- Control outputs are registered Moore decodes of the state.
- IDLE: `dp_rst`=1, `rst_out`=1, all enables and wraps 0, `busy`=0. `start`=1 latches `a_in`, `b_in`, `c_in` into the `bin_*` registers; next state is CLR.
- CLR, 1 cycle: `dp_rst`=1, `rst_out`=1, enables 0.
- FILL: `en_prg`=1, `en_sr_a`=1, `en_sr_b`=1, wraps 0, `rst_out`=1.
- MUL: `en_prg`=1, `en_sr_a`=0 (A frozen), `en_sr_b`=1, `wrap_mode_b`=1, `rst_out`=0 (counting starts).
- ADD: as MUL, plus `start_add`=1 and `en_c_bank`=1.
- DRAIN: `en_sr_b`=1, `wrap_mode_b`=1, `rst_out`=0, `start_add`=1, `en_c_bank`=1, `en_prg`=0.
- CAPTURE, 1 cycle: outputs as DRAIN. The closing edge loads `result` ← `acc_in` and sets the `done` register.
  - `start`=1 → CLR and latch new operands.
  - Otherwise → IDLE.
- `wrap_mode_a` is 0 in every state.
- `start` in CLR..DRAIN is ignored. Operands do not change while busy.
- `bin_*` hold their values after the job until the next accepted start.
- `result` holds until the next capture.

## Timing
- Reset (synchronous; outputs take these values the cycle after `rst` is sampled high):
  - state IDLE.
  - `dp_rst`=1, `rst_out`=1; all other controls 0.
  - `busy`=0, `done`=0, `result`=8'h00, `bin_a`/`bin_b`/`bin_c`=0.
- `rst` mid-job aborts immediately. No `done` pulse and no capture.
- Schedule, with `start` sampled at the end of cycle 0:
  - CLR in cycle 1.
  - FILL in cycles 2..`FILL_CYC`+1.
  - MUL, ADD and DRAIN follow contiguously; CAPTURE comes after DRAIN.
  - `done`=1 and the new `result` appear in the cycle after CAPTURE.
- Latency from start edge to `done` = `FILL_CYC`+`MUL_CYC`+`ADD_CYC`+`DRAIN_CYC`+3. With defaults this is 54 cycles: CAPTURE = cycle 53, `done` = cycle 54.
- `busy` is high in cycles 1..53 with defaults.
- Back-to-back: with `start` during CAPTURE, `busy` stays high without a gap and `done` still pulses for the finished job.
- `start` high continuously: jobs repeat every 53 cycles. `start` held through IDLE starts exactly one job per acceptance.

## Test plan
- Reset with stimulus active → all outputs at reset values. `start`=1 during `rst` is ignored (stays IDLE).
- Defaults: `a_in`=5, `b_in`=2, `acc_in` stub = 8'h3B from cycle 50 → `busy` in cycles 1..53.
  - `en_sr_a` high exactly 16 cycles (2..17); `wrap_mode_b` rises at cycle 18.
  - `start_add` high cycles 35..53.
  - `done` pulse at cycle 54 only, with `result`=8'h3B.
- `a_in`/`c_in` changed and `start` pulsed while busy → `bin_*` unchanged, no new job, single `done`.
- `start` held high → second CLR in cycle 54, `done` at 54 and 107, `busy` never drops.
- `rst` asserted at cycle 30 → IDLE next cycle, `result`=0, no `done`.
- Integration with the real datapath: A=5, B=2, C sum 49 → `result` = 8'h3B ± 2.

Source files
------------

// File: rtl/pipe_mac_seq.sv
// Control sequencer for the stochastic MAC datapath: latches one job's operands,
// then steps the datapath through clear, fill, multiply, add and drain before capturing the count.
module pipe_mac_seq #(
    parameter int FILL_CYC  = 16,
    parameter int MUL_CYC   = 17,
    parameter int ADD_CYC   = 16,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  a_in,
    input  logic [3:0]  b_in,
    input  logic [63:0] c_in,
    input  logic [7:0]  acc_in,
    output logic [3:0]  bin_a,
    output logic [3:0]  bin_b,
    output logic [63:0] bin_c,
    output logic        dp_rst,
    output logic        en_prg,
    output logic        en_sr_a,
    output logic        en_sr_b,
    output logic        wrap_mode_a,
    output logic        wrap_mode_b,
    output logic        rst_out,
    output logic        en_c_bank,
    output logic        start_add,
    output logic        busy,
    output logic        done,
    output logic [7:0]  result,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_FILL, S_MUL, S_ADD, S_DRAIN, S_CAPTURE
    } state_t;

    typedef struct packed {
        logic dp_rst;
        logic en_prg;
        logic en_sr_a;
        logic en_sr_b;
        logic wrap_mode_a;
        logic wrap_mode_b;
        logic rst_out;
        logic en_c_bank;
        logic start_add;
        logic busy;
    } ctrl_t;

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYC - 1);
    localparam logic [CNT_W-1:0] MUL_LAST   = CNT_W'(MUL_CYC - 1);
    localparam logic [CNT_W-1:0] ADD_LAST   = CNT_W'(ADD_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    ctrl_t            ctrl;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IDLE: begin
                c.dp_rst  = 1'b1;
                c.rst_out = 1'b1;
            end
            S_CLR: begin
                c.dp_rst  = 1'b1;
                c.rst_out = 1'b1;
                c.busy    = 1'b1;
            end
            S_FILL: begin
                c.en_prg  = 1'b1;
                c.en_sr_a = 1'b1;
                c.en_sr_b = 1'b1;
                c.rst_out = 1'b1;
                c.busy    = 1'b1;
            end
            S_MUL: begin
                c.en_prg      = 1'b1;
                c.en_sr_b     = 1'b1;
                c.wrap_mode_b = 1'b1;
                c.busy        = 1'b1;
            end
            S_ADD: begin
                c.en_prg      = 1'b1;
                c.en_sr_b     = 1'b1;
                c.wrap_mode_b = 1'b1;
                c.en_c_bank   = 1'b1;
                c.start_add   = 1'b1;
                c.busy        = 1'b1;
            end
            default: begin
                c.en_sr_b     = 1'b1;
                c.wrap_mode_b = 1'b1;
                c.en_c_bank   = 1'b1;
                c.start_add   = 1'b1;
                c.busy        = 1'b1;
            end
        endcase
        return c;
    endfunction

    // Handshake: start is accepted only in IDLE or CAPTURE (ignored otherwise);
    // done pulses for exactly one cycle, and result is valid from that cycle until the next capture.
    assign accept = start && (state == S_IDLE || state == S_CAPTURE);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_CLR;
            S_CLR:     next_state = S_FILL;
            S_FILL:    if (cnt == FILL_LAST) next_state = S_MUL;
            S_MUL:     if (cnt == MUL_LAST) next_state = S_ADD;
            S_ADD:     if (cnt == ADD_LAST) next_state = S_DRAIN;
            S_DRAIN:   if (cnt == DRAIN_LAST) next_state = S_CAPTURE;
            S_CAPTURE: next_state = start ? S_CLR : S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so the registered controls line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ctrl   <= decode(S_IDLE);
            done   <= 1'b0;
            result <= 8'h00;
            bin_a  <= '0;
            bin_b  <= '0;
            bin_c  <= '0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
            ctrl  <= decode(next_state);
            done  <= (state == S_CAPTURE);
            if (state == S_CAPTURE) result <= acc_in;
            if (accept) begin
                bin_a <= a_in;
                bin_b <= b_in;
                bin_c <= c_in;
            end
        end
    end

    assign dp_rst      = ctrl.dp_rst;
    assign en_prg      = ctrl.en_prg;
    assign en_sr_a     = ctrl.en_sr_a;
    assign en_sr_b     = ctrl.en_sr_b;
    assign wrap_mode_a = ctrl.wrap_mode_a;
    assign wrap_mode_b = ctrl.wrap_mode_b;
    assign rst_out     = ctrl.rst_out;
    assign en_c_bank   = ctrl.en_c_bank;
    assign start_add   = ctrl.start_add;
    assign busy        = ctrl.busy;
    assign state_dbg   = state;

endmodule

// File: tb/tb_pipe_mac_seq.sv
// Bench for pipe_mac_seq: cycle-accurate schedule checks plus a result scoreboard
// fed when a job is launched and drained on each done pulse.
module tb_pipe_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  a_in;
    logic [3:0]  b_in;
    logic [63:0] c_in;
    logic [7:0]  acc_in;
    logic [3:0]  bin_a;
    logic [3:0]  bin_b;
    logic [63:0] bin_c;
    logic        dp_rst, en_prg, en_sr_a, en_sr_b, wrap_mode_a, wrap_mode_b;
    logic        rst_out, en_c_bank, start_add, busy, done;
    logic [7:0]  result;
    logic [2:0]  state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    pipe_mac_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .acc_in(acc_in),
        .bin_a(bin_a), .bin_b(bin_b), .bin_c(bin_c),
        .dp_rst(dp_rst), .en_prg(en_prg), .en_sr_a(en_sr_a), .en_sr_b(en_sr_b),
        .wrap_mode_a(wrap_mode_a), .wrap_mode_b(wrap_mode_b),
        .rst_out(rst_out), .en_c_bank(en_c_bank), .start_add(start_add),
        .busy(busy), .done(done), .result(result), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] ctl;
        rst    = 1'b1;
        start  = 1'b1;
        a_in   = 4'($urandom_range(1, 15));
        b_in   = 4'($urandom_range(1, 15));
        c_in   = {$urandom, $urandom};
        acc_in = 8'($urandom_range(1, 255));
        repeat (3) step();
        ctl = {dp_rst, rst_out, en_prg, en_sr_a, en_sr_b, wrap_mode_a,
               wrap_mode_b, en_c_bank, start_add, busy};
        tests_run++;
        if (ctl !== 10'b11_0000_0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected %b", ctl, 10'b11_0000_0000);
        end
        tests_run++;
        if ({done, result} !== 9'h000) begin
            tests_failed++;
            $display("FAIL reset_result: got done=%b result=%h expected done=0 result=00", done, result);
        end
        tests_run++;
        if ({bin_a, bin_b, bin_c} !== 72'h0) begin
            tests_failed++;
            $display("FAIL reset_bin: got %h/%h/%h expected 0/0/0", bin_a, bin_b, bin_c);
        end
        tests_run++;
        if (state_dbg !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        tests_run++;
        if (state_dbg !== 3'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got state=%0d busy=%b expected state=0 busy=0", state_dbg, busy);
        end
    endtask

    task automatic test_schedule();
        logic [7:0] exp_r;
        logic [63:0] cv;
        int sr_a_cnt = 0;
        cv     = {$urandom, $urandom};
        a_in   = 4'd5;
        b_in   = 4'd2;
        c_in   = cv;
        acc_in = 8'h00;
        start  = 1'b1;
        exp_q.push_back(8'h3B);
        for (int cyc = 1; cyc <= 56; cyc++) begin
            step();
            start  = 1'b0;
            acc_in = (cyc >= 50) ? 8'h3B : 8'h00;
            if (en_sr_a === 1'b1) sr_a_cnt++;
            tests_run++;
            if (busy !== (cyc <= 53)) begin
                tests_failed++;
                $display("FAIL sched_busy c%0d: got %b expected %b", cyc, busy, cyc <= 53);
            end
            tests_run++;
            if (en_sr_a !== (cyc >= 2 && cyc <= 17)) begin
                tests_failed++;
                $display("FAIL sched_en_sr_a c%0d: got %b", cyc, en_sr_a);
            end
            tests_run++;
            if ({en_prg, en_sr_b} !== {cyc >= 2 && cyc <= 50, cyc >= 2 && cyc <= 53}) begin
                tests_failed++;
                $display("FAIL sched_en_prg_sr_b c%0d: got %b%b", cyc, en_prg, en_sr_b);
            end
            tests_run++;
            if ({wrap_mode_a, wrap_mode_b} !== {1'b0, cyc >= 18 && cyc <= 53}) begin
                tests_failed++;
                $display("FAIL sched_wrap c%0d: got %b%b", cyc, wrap_mode_a, wrap_mode_b);
            end
            tests_run++;
            if ({start_add, en_c_bank} !== {2{cyc >= 35 && cyc <= 53}}) begin
                tests_failed++;
                $display("FAIL sched_add c%0d: got %b%b", cyc, start_add, en_c_bank);
            end
            tests_run++;
            if ({dp_rst, rst_out} !== {cyc == 1 || cyc >= 54, cyc <= 17 || cyc >= 54}) begin
                tests_failed++;
                $display("FAIL sched_resets c%0d: got %b%b", cyc, dp_rst, rst_out);
            end
            tests_run++;
            if (done !== (cyc == 54)) begin
                tests_failed++;
                $display("FAIL sched_done c%0d: got %b expected %b", cyc, done, cyc == 54);
            end
            if (cyc == 1) begin
                tests_run++;
                if ({bin_a, bin_b, bin_c} !== {4'd5, 4'd2, cv}) begin
                    tests_failed++;
                    $display("FAIL sched_latch: got %h/%h/%h expected 5/2/%h", bin_a, bin_b, bin_c, cv);
                end
            end
            if (done === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sched_result: got unexpected done expected none");
                end else begin
                    exp_r = exp_q.pop_front();
                    if (result !== exp_r) begin
                        tests_failed++;
                        $display("FAIL sched_result: got %h expected %h", result, exp_r);
                    end
                end
            end
        end
        tests_run++;
        if (sr_a_cnt != 16) begin
            tests_failed++;
            $display("FAIL sched_sr_a_len: got %0d expected 16", sr_a_cnt);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sched_missing_done: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] acc_val, exp_r;
        logic [63:0] cv;
        int n_done = 0;
        cv      = {$urandom, $urandom};
        acc_val = 8'($urandom_range(1, 255));
        a_in    = 4'd3;
        b_in    = 4'd7;
        c_in    = cv;
        acc_in  = acc_val;
        start   = 1'b1;
        exp_q.push_back(acc_val);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            step();
            start = (cyc == 10 || cyc == 30);
            if (cyc == 10) begin
                a_in = 4'd12;
                b_in = 4'd9;
                c_in = ~cv;
            end
            if (cyc == 20 || cyc == 45) begin
                tests_run++;
                if ({bin_a, bin_b, bin_c} !== {4'd3, 4'd7, cv}) begin
                    tests_failed++;
                    $display("FAIL busy_bin_hold c%0d: got %h/%h/%h expected 3/7/%h", cyc, bin_a, bin_b, bin_c, cv);
                end
            end
            if (cyc == 58) begin
                tests_run++;
                if (busy !== 1'b0 || state_dbg !== 3'd0) begin
                    tests_failed++;
                    $display("FAIL busy_no_new_job: got busy=%b state=%0d expected 0/0", busy, state_dbg);
                end
            end
            if (done === 1'b1) begin
                n_done++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL busy_result: got extra done expected none");
                end else begin
                    exp_r = exp_q.pop_front();
                    if (result !== exp_r) begin
                        tests_failed++;
                        $display("FAIL busy_result: got %h expected %h", result, exp_r);
                    end
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (n_done != 1) begin
            tests_failed++;
            $display("FAIL busy_done_count: got %0d expected 1", n_done);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] r2, exp_r;
        r2     = 8'($urandom_range(1, 255));
        a_in   = 4'd4;
        b_in   = 4'd6;
        acc_in = 8'h21;
        start  = 1'b1;
        exp_q.push_back(8'h21);
        exp_q.push_back(r2);
        for (int cyc = 1; cyc <= 112; cyc++) begin
            step();
            start  = (cyc < 100);
            a_in   = (cyc >= 40) ? 4'd9 : 4'd4;
            acc_in = (cyc <= 53) ? 8'h21 : r2;
            tests_run++;
            if (busy !== (cyc <= 106)) begin
                tests_failed++;
                $display("FAIL b2b_busy c%0d: got %b expected %b", cyc, busy, cyc <= 106);
            end
            tests_run++;
            if (done !== (cyc == 54 || cyc == 107)) begin
                tests_failed++;
                $display("FAIL b2b_done c%0d: got %b", cyc, done);
            end
            if (cyc == 54) begin
                tests_run++;
                if (state_dbg !== 3'd1 || bin_a !== 4'd9) begin
                    tests_failed++;
                    $display("FAIL b2b_reclr: got state=%0d bin_a=%h expected 1/9", state_dbg, bin_a);
                end
            end
            if (done === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_result: got extra done expected none");
                end else begin
                    exp_r = exp_q.pop_front();
                    if (result !== exp_r) begin
                        tests_failed++;
                        $display("FAIL b2b_result: got %h expected %h", result, exp_r);
                    end
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_missing_done: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mid_reset();
        a_in   = 4'($urandom_range(1, 15));
        c_in   = {$urandom, $urandom} | 64'h1;
        acc_in = 8'h77;
        start  = 1'b1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            step();
            start = 1'b0;
            rst   = (cyc == 30);
            tests_run++;
            if (done !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_no_done c%0d: got %b expected 0", cyc, done);
            end
            if (cyc == 31) begin
                tests_run++;
                if (state_dbg !== 3'd0 || busy !== 1'b0 || result !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL rst_abort: got state=%0d busy=%b result=%h expected 0/0/00", state_dbg, busy, result);
                end
                tests_run++;
                if ({dp_rst, rst_out, en_prg, en_sr_b, start_add} !== 5'b11000 || {bin_a, bin_c} !== 68'h0) begin
                    tests_failed++;
                    $display("FAIL rst_abort_ctrl: got %b bin_a=%h bin_c=%h", {dp_rst, rst_out, en_prg, en_sr_b, start_add}, bin_a, bin_c);
                end
            end
            if (cyc == 60) begin
                tests_run++;
                if (state_dbg !== 3'd0) begin
                    tests_failed++;
                    $display("FAIL rst_stay_idle: got %0d expected 0", state_dbg);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        c_in   = '0;
        acc_in = '0;
        step();
        test_reset();
        test_schedule();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
